mc_control_unit: RTL and testbench



---
 rtl/mc_ctrl_pkg.sv | 55 +++++
 rtl/mc_control_unit_alu_decoder.sv | 30 +++
 rtl/mc_control_unit.sv | 185 ++++++++++++++++++
 tb/tb_mc_control_unit.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller:
// states, opcodes, functs, ALUOp and datapath select codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ASB_B    = 2'b00;
  localparam logic [1:0] ASB_4    = 2'b01;
  localparam logic [1:0] ASB_IMM  = 2'b10;
  localparam logic [1:0] ASB_IMM2 = 2'b11;

  localparam logic [1:0] PCS_ALU  = 2'b00;
  localparam logic [1:0] PCS_OUT  = 2'b01;
  localparam logic [1:0] PCS_JUMP = 2'b10;

endpackage

// File: rtl/mc_control_unit_alu_decoder.sv
// ALU decoder: maps ALUOp and Funct to the 3-bit ALU_Control.
// Unknown Funct codes fall back to add.
module ALU_decoder
  import mc_ctrl_pkg::*;
(
  input  alu_op_t    i_alu_op,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    unique case (i_alu_op)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  o_alu_control = ALU_ADD;
          FN_SUB:  o_alu_control = ALU_SUB;
          FN_AND:  o_alu_control = ALU_AND;
          FN_OR:   o_alu_control = ALU_OR;
          FN_SLT:  o_alu_control = ALU_SLT;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS controller FSM with memory-ready handshake.
// MC_ILLEGAL_TRAP_EN traps unknown opcodes in a sticky ILLEGAL state.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         Opcode,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCEn,
  output logic [1:0]         PCSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALU_Control,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               instr_done,
`ifdef MC_ILLEGAL_TRAP_EN
  output logic               illegal_op,
`endif
  output logic [STATE_W-1:0] state_dbg
);

  state_t     r_state;
  state_t     w_next;
  alu_op_t    w_aluop;
  logic       w_iord;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_alusrca;
  logic       w_regdst;
  logic       w_memtoreg;
  logic       w_regwrite;
  logic       w_done;
  logic [1:0] w_pcsrc;
  logic [1:0] w_alusrcb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_aluop    = ALUOP_ADD;
    w_iord     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_alusrca  = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_done     = 1'b0;
    w_pcsrc    = PCS_ALU;
    w_alusrcb  = ASB_B;
    unique case (r_state)
      S_FETCH: begin
        w_alusrcb = ASB_4;
        if (mem_ready) begin
          w_irwrite = 1'b1;
          w_pcwrite = 1'b1;
          w_next    = S_DECODE;
        end
      end
      S_DECODE: begin
        w_alusrcb = ASB_IMM2;
        if (Opcode == OP_LW || Opcode == OP_SW)
          w_next = S_MEMADR;
        else if (Opcode == OP_RTYPE)
          w_next = S_EXECUTE;
        else if (Opcode == OP_BEQ)
          w_next = S_BRANCH;
        else if (Opcode == OP_ADDI)
          w_next = S_ADDIEX;
        else if (Opcode == OP_J)
          w_next = S_JUMP;
        else begin
`ifdef MC_ILLEGAL_TRAP_EN
          w_next = S_ILLEGAL;
`else
          w_next = S_FETCH;
          w_done = 1'b1;
`endif
        end
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = ASB_IMM;
        w_next    = (Opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_iord = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
        w_done     = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
        if (mem_ready) begin
          w_done = 1'b1;
          w_next = S_FETCH;
        end
      end
      S_EXECUTE: begin
        w_alusrca = 1'b1;
        w_aluop   = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        w_alusrca = 1'b1;
        w_aluop   = ALUOP_SUB;
        w_pcsrc   = PCS_OUT;
        w_branch  = 1'b1;
        w_done    = 1'b1;
        w_next    = S_FETCH;
      end
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = ASB_IMM;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_done     = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        w_pcsrc   = PCS_JUMP;
        w_pcwrite = 1'b1;
        w_done    = 1'b1;
        w_next    = S_FETCH;
      end
      S_ILLEGAL: w_next = S_ILLEGAL;
      default:   w_next = S_FETCH;
    endcase
  end

  ALU_decoder u_alu_dec (
    .i_alu_op      (w_aluop),
    .i_funct       (Funct),
    .o_alu_control (ALU_Control)
  );

  // rst gates the enables so a mid-instruction reset writes nothing
  assign PCEn       = !rst && (w_pcwrite || (w_branch && Zero));
  assign IRWrite    = !rst && w_irwrite;
  assign MemWrite   = !rst && w_memwrite;
  assign RegWrite   = !rst && w_regwrite;
  assign instr_done = !rst && w_done;
  assign IorD       = w_iord;
  assign PCSrc      = w_pcsrc;
  assign ALUSrcA    = w_alusrca;
  assign ALUSrcB    = w_alusrcb;
  assign RegDst     = w_regdst;
  assign MemtoReg   = w_memtoreg;
  assign state_dbg  = STATE_W'(r_state);

`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal_op = (r_state == S_ILLEGAL);
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: expected per-cycle outputs
// are queued with their stimulus and compared as the FSM steps.
module tb_mc_control_unit;
  import mc_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_ready;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCEn;
  logic [1:0] PCSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALU_Control;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       instr_done;
  logic [3:0] state_dbg;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  int vecs = 0;
  int miss = 0;

  typedef struct {
    string       n;
    state_t      st;
    logic        mr;
    logic        z;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [15:0] o;
  } ent_t;

  ent_t q[$];

  mc_control_unit #(.STATE_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .Opcode      (Opcode),
    .Funct       (Funct),
    .Zero        (Zero),
    .mem_ready   (mem_ready),
    .IorD        (IorD),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .PCEn        (PCEn),
    .PCSrc       (PCSrc),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALU_Control (ALU_Control),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .instr_done  (instr_done),
`ifdef MC_ILLEGAL_TRAP_EN
    .illegal_op  (illegal_op),
`endif
    .state_dbg   (state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach summary");
    $fatal(1);
  end

  function automatic logic [2:0] fn_ctl(logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic known_op(logic [5:0] op);
    return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
           op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
  endfunction

  // {IorD,MemWrite,IRWrite,PCEn,PCSrc,ALUSrcA,ALUSrcB,ALU_Control,
  //  RegDst,MemtoReg,RegWrite,instr_done}
  function automatic logic [15:0] exp_o(state_t st, logic mr, logic z,
                                        logic [5:0] op, logic [5:0] fn);
    logic iord, mw, irw, pcen, asa, rdst, m2r, rw, dn, trap;
    logic [1:0] pcs, asb;
    logic [2:0] ac;
    {iord, mw, irw, pcen, asa, rdst, m2r, rw, dn} = '0;
    pcs = 2'b00;
    asb = 2'b00;
    ac  = 3'b010;
`ifdef MC_ILLEGAL_TRAP_EN
    trap = 1'b1;
`else
    trap = 1'b0;
`endif
    case (st)
      S_FETCH:    begin asb = 2'b01; irw = mr; pcen = mr; end
      S_DECODE:   begin asb = 2'b11; dn = !known_op(op) && !trap; end
      S_MEMADR:   begin asa = 1'b1; asb = 2'b10; end
      S_MEMREAD:  iord = 1'b1;
      S_MEMWB:    begin rw = 1'b1; m2r = 1'b1; dn = 1'b1; end
      S_MEMWRITE: begin iord = 1'b1; mw = 1'b1; dn = mr; end
      S_EXECUTE:  begin asa = 1'b1; ac = fn_ctl(fn); end
      S_ALUWB:    begin rdst = 1'b1; rw = 1'b1; dn = 1'b1; end
      S_BRANCH: begin
        asa = 1'b1; ac = 3'b110; pcs = 2'b01; pcen = z; dn = 1'b1;
      end
      S_ADDIEX:   begin asa = 1'b1; asb = 2'b10; end
      S_ADDIWB:   begin rw = 1'b1; dn = 1'b1; end
      S_JUMP:     begin pcs = 2'b10; pcen = 1'b1; dn = 1'b1; end
      default: ;
    endcase
    return {iord, mw, irw, pcen, pcs, asa, asb, ac, rdst, m2r, rw, dn};
  endfunction

  function automatic void push(string n, state_t st, logic mr, logic z,
                               logic [5:0] op, logic [5:0] fn);
    ent_t e;
    e.n  = n;
    e.st = st;
    e.mr = mr;
    e.z  = z;
    e.op = op;
    e.fn = fn;
    e.o  = exp_o(st, mr, z, op, fn);
    q.push_back(e);
  endfunction

  // Non-memory cycles get random mem_ready/Zero; they must be ignored.
  function automatic void push_instr(string n, logic [5:0] op,
                                     logic [5:0] fn, logic z,
                                     int sf, int sm);
    for (int i = 0; i < sf; i++) push(n, S_FETCH, 1'b0, 1'($urandom), op, fn);
    push(n, S_FETCH, 1'b1, 1'($urandom), op, fn);
    push(n, S_DECODE, 1'($urandom), 1'($urandom), op, fn);
    case (op)
      6'b100011: begin
        push(n, S_MEMADR, 1'($urandom), 1'($urandom), op, fn);
        for (int i = 0; i < sm; i++) push(n, S_MEMREAD, 1'b0, 1'($urandom), op, fn);
        push(n, S_MEMREAD, 1'b1, 1'($urandom), op, fn);
        push(n, S_MEMWB, 1'($urandom), 1'($urandom), op, fn);
      end
      6'b101011: begin
        push(n, S_MEMADR, 1'($urandom), 1'($urandom), op, fn);
        for (int i = 0; i < sm; i++) push(n, S_MEMWRITE, 1'b0, 1'($urandom), op, fn);
        push(n, S_MEMWRITE, 1'b1, 1'($urandom), op, fn);
      end
      6'b000000: begin
        push(n, S_EXECUTE, 1'($urandom), 1'($urandom), op, fn);
        push(n, S_ALUWB, 1'($urandom), 1'($urandom), op, fn);
      end
      6'b000100: push(n, S_BRANCH, 1'($urandom), z, op, fn);
      6'b001000: begin
        push(n, S_ADDIEX, 1'($urandom), 1'($urandom), op, fn);
        push(n, S_ADDIWB, 1'($urandom), 1'($urandom), op, fn);
      end
      6'b000010: push(n, S_JUMP, 1'($urandom), 1'($urandom), op, fn);
      default: ;
    endcase
  endfunction

  // Entered and left at posedge+1; compares each entry at negedge.
  task automatic drain();
    ent_t e;
    logic [15:0] got;
    while (q.size() > 0) begin
      e = q.pop_front();
      Opcode    = e.op;
      Funct     = e.fn;
      mem_ready = e.mr;
      Zero      = e.z;
      @(negedge clk);
      got = {IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
             ALU_Control, RegDst, MemtoReg, RegWrite, instr_done};
      vecs++;
      if (state_dbg !== e.st || got !== e.o) begin
        miss++;
        $display("FAIL %s: state %0d outs %h, expected state %0d outs %h",
                 e.n, state_dbg, got, e.st, e.o);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; Zero = 1'b0;
    Opcode = 6'b000000; Funct = 6'b000000;
    #2;
    vecs++;
    if (state_dbg !== 4'(S_FETCH) || IRWrite !== 1'b0 || PCEn !== 1'b0 ||
        MemWrite !== 1'b0 || RegWrite !== 1'b0 || instr_done !== 1'b0 ||
        ALUSrcB !== 2'b01) begin
      miss++;
      $display("FAIL reset_init: state %0d IRW %b PCEn %b ALUSrcB %b, expected 0 0 0 01",
               state_dbg, IRWrite, PCEn, ALUSrcB);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    push_instr("sw_reset", 6'b101011, 6'd0, 1'b0, 0, 0);
    void'(q.pop_back());
    push("sw_reset", S_MEMWRITE, 1'b0, 1'b0, 6'b101011, 6'd0);
    drain();
    vecs++;
    if (MemWrite !== 1'b1 || state_dbg !== 4'(S_MEMWRITE)) begin
      miss++;
      $display("FAIL memwrite_hold: MemWrite %b state %0d, expected 1 %0d",
               MemWrite, state_dbg, S_MEMWRITE);
    end
    rst = 1'b1;
    #1;
    vecs++;
    if (MemWrite !== 1'b0 || state_dbg !== 4'(S_FETCH)) begin
      miss++;
      $display("FAIL reset_async: MemWrite %b state %0d, expected 0 0",
               MemWrite, state_dbg);
    end
    mem_ready = 1'b1;
    #1;
    vecs++;
    if (IRWrite !== 1'b0 || PCEn !== 1'b0) begin
      miss++;
      $display("FAIL reset_gate: IRWrite %b PCEn %b, expected 0 0", IRWrite, PCEn);
    end
    rst = 1'b0;
    #1;
    vecs++;
    if (IRWrite !== 1'b1 || PCEn !== 1'b1 || state_dbg !== 4'(S_FETCH)) begin
      miss++;
      $display("FAIL reset_release: IRWrite %b PCEn %b state %0d, expected 1 1 0",
               IRWrite, PCEn, state_dbg);
    end
    mem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    push_instr("lw", OP_LW, 6'd0, 1'b0, 0, 0);
    drain();
  endtask

  task automatic test_rtype();
    logic [5:0] fns [6];
    fns = '{6'b100010, 6'b100000, 6'b100100, 6'b100101, 6'b101010, 6'b111000};
    foreach (fns[i]) push_instr("rtype", OP_RTYPE, fns[i], 1'b0, 0, 0);
    drain();
  endtask

  task automatic test_beq();
    push_instr("beq_z1", OP_BEQ, 6'd0, 1'b1, 0, 0);
    push_instr("beq_z0", OP_BEQ, 6'd0, 1'b0, 0, 0);
    drain();
  endtask

  task automatic test_addi_j();
    push_instr("addi", OP_ADDI, 6'd0, 1'b0, 0, 0);
    push_instr("j", OP_J, 6'd0, 1'b0, 0, 0);
    drain();
  endtask

  task automatic test_stall();
    push_instr("sw_stall", OP_SW, 6'd0, 1'b0, 3, 3);
    push_instr("lw_stall", OP_LW, 6'd0, 1'b0, 1, 2);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [6];
    ops = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};
    for (int k = 0; k < 24; k++) begin
      push_instr("b2b", ops[$urandom_range(0, 5)], 6'($urandom),
                 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    end
    drain();
  endtask

  task automatic test_illegal();
    push_instr("illegal", 6'b111111, 6'd0, 1'b0, 0, 0);
`ifdef MC_ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++)
      push("illegal_trap", S_ILLEGAL, 1'($urandom), 1'($urandom), 6'b111111, 6'd0);
    drain();
    vecs++;
    if (illegal_op !== 1'b1) begin
      miss++;
      $display("FAIL illegal_sticky: illegal_op %b, expected 1", illegal_op);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vecs++;
    if (illegal_op !== 1'b0 || state_dbg !== 4'(S_FETCH)) begin
      miss++;
      $display("FAIL illegal_clear: illegal_op %b state %0d, expected 0 0",
               illegal_op, state_dbg);
    end
`else
    push("illegal_nop", S_FETCH, 1'b0, 1'b0, 6'b111111, 6'd0);
    drain();
`endif
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_addi_j();
    test_stall();
    test_back_to_back();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
